// File: rtl/pim_mem_ctrl_pkg.sv
// Shared widths, FSM state encoding and request record for the PIM DRAM row controller.
package pim_mem_ctrl_pkg;

  localparam int ADDRESS_LEN        = 16;
  localparam int BURST_ACCESS_WIDTH = 32;
  localparam int BURST_LEN          = 4;
  localparam int ROW_WIDTH          = BURST_LEN * BURST_ACCESS_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RDY,
    ACCESS,
    RESP
  } ctrl_state_t;

  typedef struct packed {
    logic                   write;
    logic [ADDRESS_LEN-1:0] addr;
    logic [ROW_WIDTH-1:0]   wdata;
  } mem_req_t;

endpackage

// File: rtl/pim_row_buf.sv
// Row staging register: whole-row load, single-beat load, and a beat-indexed read mux.
module pim_row_buf
  import pim_mem_ctrl_pkg::*;
#(
  parameter  int BEAT_W = 32,
  parameter  int NBEATS = 4,
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1,
  localparam int ROW_W  = BEAT_W * NBEATS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_all_i,
  input  logic [ROW_W-1:0]  row_i,
  input  logic              load_beat_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [BEAT_W-1:0] beat_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [ROW_W-1:0]  row_o,
  output logic [BEAT_W-1:0] beat_o
);

  logic [ROW_W-1:0] row_q, row_d;

  // A whole-row load wins over a beat load; the FSM never requests both at once.
  always_comb begin
    row_d = row_q;
    if (load_all_i) begin
      row_d = row_i;
    end else if (load_beat_i) begin
      row_d[int'(wr_idx_i) * BEAT_W +: BEAT_W] = beat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  assign row_o  = row_q;
  assign beat_o = row_q[int'(rd_idx_i) * BEAT_W +: BEAT_W];

endmodule

// File: rtl/pim_mem_ctrl.sv
// DRAM row-access initiator: takes whole-row requests, bursts them as beats, and
// returns one response per request with a watchdog abort.
module pim_mem_ctrl #(
  parameter int ADDRESS_LEN        = pim_mem_ctrl_pkg::ADDRESS_LEN,
  parameter int BURST_ACCESS_WIDTH = pim_mem_ctrl_pkg::BURST_ACCESS_WIDTH,
  parameter int BURST_LEN          = pim_mem_ctrl_pkg::BURST_LEN,
  parameter int ROW_WIDTH          = BURST_LEN * BURST_ACCESS_WIDTH,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDRESS_LEN-1:0]        req_addr,
  input  logic [ROW_WIDTH-1:0]          req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ROW_WIDTH-1:0]          resp_rdata,
  output logic                          resp_err,
  output logic                          busy,
  output logic                          read_en,
  output logic                          write_en,
  output logic [ADDRESS_LEN-1:0]        addr,
  output logic [BURST_ACCESS_WIDTH-1:0] wdata,
  input  logic                          dram_ready,
  input  logic                          dram_complete,
  input  logic [BURST_ACCESS_WIDTH-1:0] rdata,
  input  logic                          valid
);

  import pim_mem_ctrl_pkg::*;

  localparam int IDX_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int CNT_W   = $clog2(BURST_LEN + 1);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  ctrl_state_t                   state_q, state_d;
  logic [ADDRESS_LEN-1:0]        addr_q, addr_d;
  logic                          write_q, write_d;
  logic                          rdEn_q, rdEn_d;
  logic                          wrEn_q, wrEn_d;
  logic [BURST_ACCESS_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]              beatCnt_q, beatCnt_d;
  logic [TIMER_W-1:0]            timer_q, timer_d;
  logic                          err_q, err_d;
  logic                          busy_q, busy_d;
  logic                          respValid_q, respValid_d;

  logic                          bufLoadAll;
  logic [ROW_WIDTH-1:0]          bufRowIn;
  logic                          bufLoadBeat;
  logic [IDX_W-1:0]              bufWrIdx;
  logic [IDX_W-1:0]              bufRdIdx;
  logic [ROW_WIDTH-1:0]          bufRow;
  logic [BURST_ACCESS_WIDTH-1:0] bufBeat;

  pim_row_buf #(
    .BEAT_W (BURST_ACCESS_WIDTH),
    .NBEATS (BURST_LEN)
  ) u_row_buf (
    .clk         (clk),
    .rst         (rst),
    .load_all_i  (bufLoadAll),
    .row_i       (bufRowIn),
    .load_beat_i (bufLoadBeat),
    .wr_idx_i    (bufWrIdx),
    .beat_i      (rdata),
    .rd_idx_i    (bufRdIdx),
    .row_o       (bufRow),
    .beat_o      (bufBeat)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    rdEn_d      = rdEn_q;
    wrEn_d      = wrEn_q;
    wdata_d     = wdata_q;
    beatCnt_d   = beatCnt_q;
    timer_d     = timer_q;
    err_d       = err_q;
    busy_d      = busy_q;
    respValid_d = respValid_q;
    bufLoadAll  = 1'b0;
    bufRowIn    = '0;
    bufLoadBeat = 1'b0;
    bufWrIdx    = '0;
    bufRdIdx    = '0;

    case (state_q)
      IDLE: begin
        // Reads start from a cleared row so beats never delivered read back as zero.
        if (req_valid) begin
          addr_d     = req_addr;
          write_d    = req_write;
          bufLoadAll = 1'b1;
          bufRowIn   = req_write ? req_wdata : '0;
          beatCnt_d  = '0;
          timer_d    = '0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = WAIT_RDY;
        end
      end

      WAIT_RDY: begin
        if (dram_ready) begin
          wrEn_d  = write_q;
          rdEn_d  = !write_q;
          wdata_d = write_q ? bufBeat : '0;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        timer_d = timer_q + 1'b1;
        // wdata runs one beat ahead so the DRAM sees beat k during its k-th valid cycle.
        if (valid && (beatCnt_q < CNT_W'(BURST_LEN))) begin
          if (write_q) begin
            bufRdIdx = IDX_W'(beatCnt_q + 1'b1);
            wdata_d  = ((beatCnt_q + 1'b1) == CNT_W'(BURST_LEN)) ? '0 : bufBeat;
          end else begin
            bufLoadBeat = 1'b1;
            bufWrIdx    = IDX_W'(beatCnt_q);
          end
          beatCnt_d = beatCnt_q + 1'b1;
        end
        if (dram_complete) begin
          rdEn_d      = 1'b0;
          wrEn_d      = 1'b0;
          err_d       = (beatCnt_d != CNT_W'(BURST_LEN));
          respValid_d = 1'b1;
          state_d     = RESP;
        end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          rdEn_d      = 1'b0;
          wrEn_d      = 1'b0;
          err_d       = 1'b1;
          respValid_d = 1'b1;
          state_d     = RESP;
        end
      end

      RESP: begin
        if (resp_ready) begin
          respValid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      rdEn_q      <= 1'b0;
      wrEn_q      <= 1'b0;
      wdata_q     <= '0;
      beatCnt_q   <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      respValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      rdEn_q      <= rdEn_d;
      wrEn_q      <= wrEn_d;
      wdata_q     <= wdata_d;
      beatCnt_q   <= beatCnt_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      respValid_q <= respValid_d;
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = respValid_q;
  assign resp_rdata = (respValid_q && !write_q) ? bufRow : '0;
  assign resp_err   = err_q && respValid_q;
  assign busy       = busy_q;
  assign read_en    = rdEn_q;
  assign write_en   = wrEn_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;

endmodule

// File: tb/tb_pim_mem_ctrl.sv
// Scoreboard bench for pim_mem_ctrl: a behavioural DRAM responder plus a row-level reference memory.
module tb_pim_mem_ctrl;
  import pim_mem_ctrl_pkg::*;

  localparam int TB_TIMEOUT = 16;
  localparam int BW = BURST_ACCESS_WIDTH;

  typedef struct {
    mem_req_t req;
    int       nb;
    bit       complete;
  } dramMode_t;

  typedef struct {
    logic [ROW_WIDTH-1:0] rdata;
    logic                 err;
  } expResp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic req_write = 1'b0;
  logic [ADDRESS_LEN-1:0] req_addr = '0;
  logic [ROW_WIDTH-1:0] req_wdata = '0;
  logic resp_valid;
  logic resp_ready;
  logic [ROW_WIDTH-1:0] resp_rdata;
  logic resp_err;
  logic busy;
  logic read_en;
  logic write_en;
  logic [ADDRESS_LEN-1:0] addr;
  logic [BW-1:0] wdata;
  logic dram_ready;
  logic dram_complete;
  logic [BW-1:0] rdata;
  logic valid;

  int vectors = 0;
  int miscompares = 0;
  int stallCount = 0;

  dramMode_t modeQ[$];
  expResp_t  expQ[$];
  logic [ROW_WIDTH-1:0] refMem [logic [ADDRESS_LEN-1:0]];
  logic [ROW_WIDTH-1:0] dramMem [logic [ADDRESS_LEN-1:0]];

  always #5 clk = ~clk;

  pim_mem_ctrl #(
    .ADDRESS_LEN        (ADDRESS_LEN),
    .BURST_ACCESS_WIDTH (BW),
    .BURST_LEN          (BURST_LEN),
    .ROW_WIDTH          (ROW_WIDTH),
    .TIMEOUT_CYCLES     (TB_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .busy          (busy),
    .read_en       (read_en),
    .write_en      (write_en),
    .addr          (addr),
    .wdata         (wdata),
    .dram_ready    (dram_ready),
    .dram_complete (dram_complete),
    .rdata         (rdata),
    .valid         (valid)
  );

  task automatic checkOutput(input string name, input logic [ROW_WIDTH-1:0] act,
                             input logic [ROW_WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: wait bound expired or unexpected event", name);
  endtask

  function automatic logic [BW-1:0] beatOf(input logic [ROW_WIDTH-1:0] row, input int k);
    logic [ROW_WIDTH-1:0] t;
    if (k >= BURST_LEN) return '0;
    t = row >> (k * BW);
    return t[BW-1:0];
  endfunction

  function automatic logic [ROW_WIDTH-1:0] randRow();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic ensureRow(input logic [ADDRESS_LEN-1:0] a);
    logic [ROW_WIDTH-1:0] r;
    if (!refMem.exists(a)) begin
      r = randRow();
      refMem[a]  = r;
      dramMem[a] = r;
    end
  endtask

  // Model: the DRAM delivers nb beats; the first min(nb, BURST_LEN) land in the row.
  task automatic applyStimulus(input bit wr, input logic [ADDRESS_LEN-1:0] a,
                               input logic [ROW_WIDTH-1:0] row, input int nb,
                               input bit complete, input bit expectResp);
    dramMode_t m;
    expResp_t e;
    logic [ROW_WIDTH-1:0] cur;
    int nEff;
    bit got;
    ensureRow(a);
    nEff = (nb < BURST_LEN) ? nb : BURST_LEN;
    cur = refMem[a];
    e.rdata = '0;
    for (int k = 0; k < nEff; k++) begin
      if (wr) cur[k*BW +: BW] = row[k*BW +: BW];
      else    e.rdata[k*BW +: BW] = cur[k*BW +: BW];
    end
    e.err = !complete || (nb < BURST_LEN);
    if (wr) refMem[a] = cur;
    m.req.write = wr;
    m.req.addr  = a;
    m.req.wdata = row;
    m.nb        = nb;
    m.complete  = complete;
    modeQ.push_back(m);
    if (expectResp) expQ.push_back(e);
    got = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    if (!got) begin
      failNow("req_ready_wait");
    end else begin
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = row;
      @(negedge clk);
      req_valid = 1'b0;
      req_wdata = randRow();
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_read_en"}, read_en, 0);
    checkOutput({tag, "_write_en"}, write_en, 0);
    checkOutput({tag, "_addr"}, addr, 0);
    checkOutput({tag, "_wdata"}, wdata, 0);
    checkOutput({tag, "_resp_valid"}, resp_valid, 0);
    checkOutput({tag, "_resp_rdata"}, resp_rdata, 0);
    checkOutput({tag, "_resp_err"}, resp_err, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_req_ready"}, req_ready, 0);
  endtask

  // DRAM responder: one access at a time, with a bounded number of idle gaps.
  task automatic serveAccess();
    dramMode_t m;
    logic [ROW_WIDTH-1:0] row;
    int k, enCycles, idleUsed;
    bit aborted, done;
    if (modeQ.size() == 0) begin
      failNow("unexpected_access");
      m.req.write = write_en;
      m.req.addr  = addr;
      m.req.wdata = '0;
      m.nb        = 0;
      m.complete  = 1;
    end else begin
      m = modeQ.pop_front();
      checkOutput("access_dir", write_en, m.req.write);
      checkOutput("access_addr", addr, m.req.addr);
    end
    dram_ready = 1'b0;
    k = 0; enCycles = 0; idleUsed = 0; aborted = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0) @(negedge clk);
      valid = 1'b0;
      dram_complete = 1'b0;
      if (rst) begin
        aborted = 1;
        done = 1;
      end else if (!(read_en || write_en)) begin
        done = 1;
      end else begin
        enCycles++;
        if (k < m.nb && (idleUsed >= 3 || $urandom_range(0, 2) != 0)) begin
          valid = 1'b1;
          if (m.req.write) begin
            checkOutput("wdata_beat", wdata, beatOf(m.req.wdata, k));
            if (k < BURST_LEN && dramMem.exists(m.req.addr)) begin
              row = dramMem[m.req.addr];
              row[k*BW +: BW] = wdata;
              dramMem[m.req.addr] = row;
            end
          end else if (k < BURST_LEN && dramMem.exists(m.req.addr)) begin
            rdata = beatOf(dramMem[m.req.addr], k);
          end else begin
            rdata = $urandom();
          end
          k++;
        end else if (k < m.nb) begin
          idleUsed++;
        end
        if (m.complete && k == m.nb && (!valid || $urandom_range(0, 1) == 1))
          dram_complete = 1'b1;
      end
    end
    valid = 1'b0;
    dram_complete = 1'b0;
    if (!done) failNow("access_end_wait");
    else if (!aborted && !m.complete) checkOutput("access_cycles", enCycles, TB_TIMEOUT);
    if (!aborted) repeat ($urandom_range(0, 2)) @(negedge clk);
    dram_ready = 1'b1;
  endtask

  initial begin : responder
    dram_ready = 1'b1;
    valid = 1'b0;
    dram_complete = 1'b0;
    rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && (read_en || write_en)) serveAccess();
    end
  end

  // Monitor: pops the scoreboard on every accepted response and checks hold stability.
  initial begin : monitor
    expResp_t e;
    logic [ROW_WIDTH-1:0] snapRdata;
    logic snapErr;
    bit seen, readyNext;
    resp_ready = 1'b0;
    seen = 0;
    snapRdata = '0;
    snapErr = 1'b0;
    forever begin
      @(negedge clk);
      if (read_en === 1'b1 && write_en === 1'b1) failNow("enables_both_high");
      if (resp_valid === 1'b1) begin
        if (seen) begin
          checkOutput("resp_rdata_stable", resp_rdata, snapRdata);
          checkOutput("resp_err_stable", resp_err, snapErr);
        end else begin
          seen = 1;
          snapRdata = resp_rdata;
          snapErr = resp_err;
        end
        checkOutput("req_ready_in_resp", req_ready, 0);
        if (stallCount > 0) begin
          stallCount--;
          readyNext = 0;
        end else begin
          readyNext = ($urandom_range(0, 2) != 0);
        end
        resp_ready = readyNext;
        if (readyNext) begin
          if (expQ.size() == 0) begin
            failNow("unexpected_resp");
          end else begin
            e = expQ.pop_front();
            checkOutput("resp_rdata", resp_rdata, e.rdata);
            checkOutput("resp_err", resp_err, e.err);
          end
        end
      end else begin
        seen = 0;
        resp_ready = ($urandom_range(0, 1) == 1);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL global_watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [ROW_WIDTH-1:0] row;
    bit got;
    int r, nb;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;

    row = 128'h44444444_33333333_22222222_11111111;
    refMem[16'h0005]  = row;
    dramMem[16'h0005] = row;
    applyStimulus(0, 16'h0005, '0, 4, 1, 1);
    applyStimulus(1, 16'h0003, 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA, 4, 1, 1);
    applyStimulus(0, 16'h0003, '0, 4, 1, 1);
    applyStimulus(0, 16'h0009, '0, 0, 0, 1);
    applyStimulus(0, 16'h0009, '0, 4, 1, 1);
    applyStimulus(0, 16'h0005, '0, 3, 1, 1);
    applyStimulus(1, 16'h000A, randRow(), 5, 1, 1);
    applyStimulus(0, 16'h000A, '0, 5, 1, 1);
    applyStimulus(1, 16'h000B, randRow(), 2, 0, 1);
    applyStimulus(0, 16'h000B, '0, 4, 1, 1);

    // Abort a read two cycles into its access; it must yield no response.
    applyStimulus(0, 16'h0007, '0, 0, 0, 0);
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (read_en) got = 1;
    end
    if (!got) failNow("reset_test_read_en");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("midreset");
    rst = 1'b0;
    applyStimulus(0, 16'h0005, '0, 4, 1, 1);

    stallCount = 5;
    applyStimulus(0, 16'h0003, '0, 4, 1, 1);
    applyStimulus(1, 16'h000C, randRow(), 4, 1, 1);
    applyStimulus(0, 16'h000C, '0, 4, 1, 1);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      nb = (r == 0) ? 3 : (r == 1) ? 5 : (r == 2) ? 2 : 4;
      applyStimulus($urandom_range(0, 1), ADDRESS_LEN'($urandom_range(0, 7)), randRow(), nb,
                    ($urandom_range(0, 9) != 0), 1);
    end

    got = 0;
    for (int c = 0; c < 1000 && !got; c++) begin
      @(negedge clk);
      if (expQ.size() == 0 && modeQ.size() == 0 && !resp_valid) got = 1;
    end
    if (!got) failNow("drain_wait");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
